psum_adder_arbiter: RTL and testbench

//  Shares one 40-bit carry-select adder (carrySelectAdder40bit) among NUM_REQ

---
 rtl/psum_adder_arbiter.sv | 113 +++++++++++
 tb/tb_psum_adder_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/psum_adder_arbiter.sv
// Round-robin arbiter sharing one 40-bit carry-select adder among NUM_REQ
// partial-sum accumulators; last beats publish the final sum on one output port.
module psum_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*40-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [39:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready
);

  localparam int unsigned W      = 40;
  localparam int unsigned BLK_W  = 4;
  localparam int unsigned N_BLKS = W / BLK_W;

  // Carry-select: every 4-bit block precomputes both carry-in cases, the
  // incoming carry picks one. Carry-out of the top block is dropped.
  function automatic logic [W-1:0] csa40(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]     s;
    logic             c;
    logic [BLK_W:0]   s0;
    logic [BLK_W:0]   s1;
    s = '0;
    c = 1'b0;
    for (int unsigned blk = 0; blk < N_BLKS; blk++) begin
      s0 = {1'b0, a[BLK_W*blk +: BLK_W]} + {1'b0, b[BLK_W*blk +: BLK_W]};
      s1 = s0 + 5'd1;
      s[BLK_W*blk +: BLK_W] = c ? s1[BLK_W-1:0] : s0[BLK_W-1:0];
      c = c ? s1[BLK_W] : s0[BLK_W];
    end
    return s;
  endfunction

  logic [W-1:0]       acc [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] elig;
  logic               slot_free;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_last;
  logic [W-1:0]       acc_sel;
  logic [W-1:0]       data_sel;
  logic [W-1:0]       sum;
  logic [ID_W-1:0]    rr_next;
  int unsigned        scan;

  assign slot_free = !out_valid || out_ready;

  // A last beat may only win when the output register can take its result,
  // so a stalled last beat never blocks non-last traffic from others.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = !rst && req_valid[i] && (!req_last[i] || slot_free);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_last  = 1'b0;
    acc_sel   = '0;
    data_sel  = '0;
    req_ready = '0;
    scan      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!gnt_found && elig[scan]) begin
        gnt_found       = 1'b1;
        gnt_idx         = ID_W'(scan);
        gnt_last        = req_last[scan];
        acc_sel         = acc[scan];
        data_sel        = req_data[scan*W +: W];
        req_ready[scan] = 1'b1;
      end
    end
  end

  assign sum     = csa40(acc_sel, data_sel);
  assign rr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) acc[i] <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (gnt_found) begin
        rr_ptr <= rr_next;
        if (gnt_last) begin
          out_data     <= sum;
          out_id       <= gnt_idx;
          out_valid    <= 1'b1;
          acc[gnt_idx] <= '0;
        end else begin
          acc[gnt_idx] <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_adder_arbiter.sv
// Directed vector table plus reset and randomized scoreboard sequences for
// psum_adder_arbiter with four requesters.
module tb_psum_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [159:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [39:0]  out_data;
  logic [1:0]   out_id;
  logic         out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  psum_adder_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  // Lane i always receives d + i, so a wrong-lane select shows up in the sum.
  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [39:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [39:0] od;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] v, input logic [3:0] l, input logic [39:0] d,
                              input logic ordy, input logic [3:0] rdy, input logic ov,
                              input logic [39:0] od, input logic [1:0] id);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.ordy = ordy; t.rdy = rdy; t.ov = ov; t.od = od; t.id = id;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [39:0] d,
                       input logic ordy);
    req_valid = v;
    req_last  = l;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) req_data[i*40 +: 40] = d + 40'(i);
  endtask

  logic [39:0] m_acc [4];
  logic [1:0]  m_rr;
  logic        m_ov;
  logic [39:0] m_od;
  logic [1:0]  m_id;

  initial begin
    rst = 1'b1;
    drive(4'b1111, 4'b0000, 40'd1, 1'b1);
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_data", 64'(out_data), 64'h0);
    chk("reset_out_id", 64'(out_id), 64'h0);
    rst = 1'b0;

    // Build up partial sums and a pending result, then reset mid-activity.
    drive(4'b0111, 4'b0100, 40'd100, 1'b1);
    @(negedge clk);
    drive(4'b0111, 4'b0100, 40'd100, 1'b1);
    @(negedge clk);
    drive(4'b0111, 4'b0100, 40'd100, 1'b1);
    @(negedge clk);
    chk("pre_reset_out_valid", 64'(out_valid), 64'h1);
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'h0);
    chk("async_reset_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    add(4'b0001, 4'b0001, 40'd5, 1, 4'b0001, 1, 40'd5, 2'd0);
    add(4'b0010, 4'b0000, 40'd2, 1, 4'b0010, 0, 40'd5, 2'd0);
    add(4'b0010, 4'b0000, 40'd6, 1, 4'b0010, 0, 40'd5, 2'd0);
    add(4'b0010, 4'b0010, 40'hFF_FFFF_FFFE, 1, 4'b0010, 1, 40'd9, 2'd1);
    add(4'b1000, 4'b0000, 40'd0, 1, 4'b1000, 0, 40'd9, 2'd1);
    for (int r = 0; r < 8; r++)
      add(4'b1111, 4'b0000, 40'h10, 1, 4'(1 << (r % 4)), 0, 40'd9, 2'd1);
    add(4'b0100, 4'b0000, 40'd0, 1, 4'b0100, 0, 40'd9, 2'd1);
    add(4'b0101, 4'b0000, 40'd0, 1, 4'b0001, 0, 40'd9, 2'd1);
    add(4'b0101, 4'b0000, 40'd0, 1, 4'b0100, 0, 40'd9, 2'd1);
    add(4'b0001, 4'b0001, 40'd0, 1, 4'b0001, 1, 40'h20, 2'd0);
    add(4'b0011, 4'b0001, 40'd5, 0, 4'b0010, 1, 40'h20, 2'd0);
    add(4'b0011, 4'b0001, 40'd5, 0, 4'b0010, 1, 40'h20, 2'd0);
    add(4'b0011, 4'b0001, 40'd5, 1, 4'b0001, 1, 40'd5, 2'd0);
    add(4'b1000, 4'b0000, 40'd0, 1, 4'b1000, 0, 40'd5, 2'd0);
    add(4'b1111, 4'b1111, 40'h100, 1, 4'b0001, 1, 40'h100, 2'd0);
    add(4'b1111, 4'b1111, 40'h100, 1, 4'b0010, 1, 40'h12F, 2'd1);
    add(4'b1111, 4'b1111, 40'h100, 1, 4'b0100, 1, 40'h12A, 2'd2);
    add(4'b1111, 4'b1111, 40'h100, 1, 4'b1000, 1, 40'h12F, 2'd3);
    add(4'b0000, 4'b0000, 40'd0, 1, 4'b0000, 0, 40'h12F, 2'd3);

    foreach (vecs[n]) begin
      drive(vecs[n].v, vecs[n].l, vecs[n].d, vecs[n].ordy);
      #1;
      chk($sformatf("vec%0d_req_ready", n), 64'(req_ready), 64'(vecs[n].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", n), 64'(out_valid), 64'(vecs[n].ov));
      chk($sformatf("vec%0d_out_data", n), 64'(out_data), 64'(vecs[n].od));
      chk($sformatf("vec%0d_out_id", n), 64'(out_id), 64'(vecs[n].id));
      @(negedge clk);
    end

    rst = 1'b1;
    drive(4'b0000, 4'b0000, 40'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_rr = '0; m_ov = 1'b0; m_od = '0; m_id = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0]  v, l, elig, exp_rdy;
      logic [39:0] lane [4];
      logic        ordy, found;
      logic [1:0]  g, p;
      logic [39:0] s;
      v = 4'($urandom());
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        l[i] = ($urandom_range(0, 3) == 0);
        lane[i] = 40'({$urandom(), $urandom()});
        req_data[i*40 +: 40] = lane[i];
      end
      req_valid = v; req_last = l; out_ready = ordy;
      elig = v & ~(l & {4{m_ov && !ordy}});
      found = 1'b0; g = '0; exp_rdy = '0;
      for (int k = 0; k < 4; k++) begin
        p = m_rr + 2'(k);
        if (!found && elig[p]) begin found = 1'b1; g = p; exp_rdy[p] = 1'b1; end
      end
      #1;
      chk("rand_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rand_onehot0", 64'($onehot0(req_ready)), 64'h1);
      @(posedge clk);
      if (ordy) m_ov = 1'b0;
      if (found) begin
        s = m_acc[g] + lane[g];
        m_rr = g + 2'd1;
        if (l[g]) begin
          m_od = s; m_id = g; m_ov = 1'b1; m_acc[g] = '0;
        end else begin
          m_acc[g] = s;
        end
      end
      #1;
      chk("rand_out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("rand_out_data", 64'(out_data), 64'(m_od));
        chk("rand_out_id", 64'(out_id), 64'(m_id));
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
